uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_counter.sv | 38 +++
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmit FSM state type and the default frame constants that both
// the transmit and receive paths import.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// Per-bit clock divider shared by the UART transmit and receive paths.
// Counts 0..CLKS_PER_BIT-1 while enabled and flags the last clock of a bit.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   clr     in  synchronous clear (owner's state is changing)
//   en      in  count enable
//   bit_end out high in the final clock of the current bit (combinational)
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign bit_end = en && (cnt_q == LAST);

  // Wrapping on bit_end keeps consecutive bits of the same state exactly
  // CLKS_PER_BIT long without needing a clear from the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || bit_end) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter.
// Accepts a word over a valid/ready handshake and sends start bit, DATA_BITS
// data bits LSB first, optional parity bit and one stop bit, each bit held for
// CLKS_PER_BIT clocks.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   tx_data    in  word to send, latched on handshake
//   tx_valid   in  producer has a word
//   tx_ready   out idle and accepting a word this cycle
//   parity_en  in  append parity bit, latched on handshake
//   parity_odd in  0 = even, 1 = odd parity, latched on handshake
//   tx         out serial line, registered, idles high
//   tx_busy    out frame in progress
//   tx_done    out one-cycle pulse in the final stop-bit cycle
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 handshake;

  assign tx_ready  = rst_n && (state_q == IDLE);
  assign tx_busy   = (state_q != IDLE);
  assign handshake = tx_valid && tx_ready;
  assign tx_done   = (state_q == STOP) && bit_end;
  assign tx        = tx_q;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_d != state_q),
    .en     (state_q != IDLE),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line level lines up with
    // the state register: no extra cycle of latency on the serial output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  // Data-side registers only need to be valid once a handshake loads them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (handshake) begin
      par_en_q  <= parity_en;
      par_bit_q <= (^tx_data) ^ parity_odd;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with CLKS_PER_BIT=4, DATA_BITS=8.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;

  logic          clk;
  logic          rst_n;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          parity_en;
  logic          parity_odd;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int total = 0;
  int bad   = 0;

  // Expected line level per cycle, starting with the cycle after a handshake.
  logic model_q[$];

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame as the line should show it: start, data LSB first, parity, stop.
  function automatic void push_frame(input logic [7:0] d, input logic pen, input logic podd);
    int ones;
    logic pbit;
    ones = 0;
    for (int k = 0; k < DB; k++) ones += int'(d[k]);
    pbit = ((ones % 2) == 1) ^ podd;
    for (int c = 0; c < CPB; c++) model_q.push_back(1'b0);
    for (int k = 0; k < DB; k++)
      for (int c = 0; c < CPB; c++) model_q.push_back(d[k]);
    if (pen)
      for (int c = 0; c < CPB; c++) model_q.push_back(pbit);
    for (int c = 0; c < CPB; c++) model_q.push_back(1'b1);
  endfunction

  task automatic start_hs(input logic [7:0] d, input logic pen, input logic podd,
                          input bit keep, output bit ok);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (tx_ready !== 1'b1) begin
      chk("hs_timeout", 32'(tx_ready), 1);
      ok = 1'b0;
      return;
    end
    tx_data    = d;
    parity_en  = pen;
    parity_odd = podd;
    tx_valid   = 1'b1;
    @(posedge clk); #1;
    if (!keep) tx_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pen, input logic podd,
                           input bit disturb, output int len_obs, output logic par_obs,
                           output logic [7:0] rx_word);
    logic cap[$];
    int   errs, flag_errs, dones, n;
    bit   ok;
    errs = 0; flag_errs = 0; dones = 0; len_obs = -1;
    rx_word = '0; par_obs = 1'b0;
    model_q.delete();
    push_frame(d, pen, podd);
    n = model_q.size();
    start_hs(d, pen, podd, 1'b0, ok);
    if (!ok) return;
    for (int i = 0; i <= n; i++) begin
      cap.push_back(tx);
      if (i < n) begin
        if (tx !== model_q[i]) errs++;
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1) flag_errs++;
      end
      if (tx_done === 1'b1) begin
        dones++;
        if (len_obs < 0) len_obs = i + 1;
      end
      if (disturb && i == 16) begin
        tx_data    = ~d;
        parity_en  = ~pen;
        parity_odd = ~podd;
      end
      if (i < n) begin
        @(posedge clk); #1;
      end
    end
    chk("wave", errs, 0);
    chk("busy_flags", flag_errs, 0);
    chk("done_count", dones, 1);
    chk("ready_back", 32'(tx_ready), 1);
    // Independent receiver: sample each bit in its middle.
    for (int k = 0; k < DB; k++) rx_word[k] = cap[CPB * (1 + k) + CPB / 2];
    if (pen) begin
      par_obs = cap[CPB * (1 + DB) + CPB / 2];
      chk("rx_parity_err", 32'((^rx_word) ^ par_obs ^ podd), 0);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       podd;
    bit         disturb;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         len;
    logic       par;
    logic [7:0] rx;
    int         ready_cnt, ready_at, dones, errs, done_seen;
    bit         ok;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 40, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 44, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 44, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 40, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 44, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 44, 1'b1};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b0, 44, 1'b1};

    rst_n = 1'b1; tx_valid = 1'b0; tx_data = '0; parity_en = 1'b0; parity_odd = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_ready", 32'(tx_ready), 0);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_done", 32'(tx_done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(tx_ready), 1);
    chk("idle_tx", 32'(tx), 1);

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].d, vecs[v].pen, vecs[v].podd, vecs[v].disturb, len, par, rx);
      chk("frame_len", len, vecs[v].exp_len);
      chk("rx_word", 32'(rx), 32'(vecs[v].d));
      if (vecs[v].pen) chk("parity_bit", 32'(par), 32'(vecs[v].exp_par));
    end

    // Back-to-back: valid held high across two frames.
    model_q.delete();
    push_frame(8'h00, 1'b0, 1'b0);
    model_q.push_back(1'b1);
    push_frame(8'hFF, 1'b0, 1'b0);
    start_hs(8'h00, 1'b0, 1'b0, 1'b1, ok);
    tx_data = 8'hFF;
    errs = 0; ready_cnt = 0; ready_at = -1; dones = 0;
    for (int i = 0; i < model_q.size(); i++) begin
      if (tx !== model_q[i]) errs++;
      if (tx_ready === 1'b1) begin
        ready_cnt++;
        if (ready_at < 0) ready_at = i;
      end
      if (tx_done === 1'b1) dones++;
      if (i == 41) tx_valid = 1'b0;
      if (i < model_q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    chk("b2b_wave", errs, 0);
    chk("b2b_ready_cycles", ready_cnt, 1);
    chk("b2b_ready_at", ready_at, 40);
    chk("b2b_done_count", dones, 2);
    @(posedge clk); #1;
    chk("b2b_idle", 32'(tx_ready), 1);

    // Reset during data bit 3 of a frame.
    start_hs(8'hA5, 1'b0, 1'b0, 1'b0, ok);
    repeat (17) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 1);
    chk("midrst_ready", 32'(tx_ready), 0);
    chk("midrst_busy", 32'(tx_busy), 0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (tx_done === 1'b1 || tx !== 1'b1) done_seen++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (tx_done === 1'b1 || tx !== 1'b1) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);
    chk("midrst_ready_back", 32'(tx_ready), 1);
    run_frame(8'h5A, 1'b1, 1'b1, 1'b0, len, par, rx);
    chk("post_rst_len", len, 44);
    chk("post_rst_rx", 32'(rx), 32'h5A);
    chk("post_rst_par", 32'(par), 1);

    // Random words with random parity, decoded by the bench receiver.
    for (int n = 0; n < 100; n++) begin
      logic [7:0] d;
      logic       pen, podd;
      d    = 8'($urandom);
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      run_frame(d, pen, podd, 1'b0, len, par, rx);
      chk("rand_rx", 32'(rx), 32'(d));
      chk("rand_len", len, pen ? 44 : 40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
